pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the next-generation single-cycle/stall-capable core. Holds the architectural PC, produces the sequential next PC, and arbitrates between sequential fetch, branch/jump redirect, trap entry and trap return. Adds a configurable reset vector, an exception PC register, a halt/resume state machine and optional misaligned-target trapping. Sits between the branch unit and the instruction-memory address port.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_next_sel.sv | 59 +++++
 rtl/pc_sequencer.sv | 82 ++++++++
 tb/tb_pc_sequencer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_pkg;

    localparam int unsigned XLEN_DEF        = 64;
    localparam int unsigned INSTR_BYTES_DEF = 4;
    localparam logic [63:0] RESET_VECTOR_DEF = 64'h0;
    localparam logic [63:0] TRAP_VECTOR_DEF  = 64'h100;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_e;

endpackage : pc_pkg

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the branch unit (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int unsigned XLEN = 64
);
    logic            enable;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_req;
    logic            trap_ret;
    logic            halt_req;
    logic            resume;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] epc;
    logic            halted;
    logic            misaligned;

    modport master (
        output enable, redirect_valid, redirect_target, trap_req, trap_ret, halt_req, resume,
        input  pc, pc_plus, epc, halted, misaligned
    );

    modport slave (
        input  enable, redirect_valid, redirect_target, trap_req, trap_ret, halt_req, resume,
        output pc, pc_plus, epc, halted, misaligned
    );
endinterface : pc_sequencer_if

// File: rtl/pc_next_sel.sv
// Combinational next-PC/EPC priority mux with optional misaligned-target trapping.
// Feature macro: PC_MISALIGN_TRAP_EN.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEF),
    parameter int unsigned     INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  pc_state_e       state,
    input  logic            enable,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic            trap_ret,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] pc_plus_c,
    output logic [XLEN-1:0] pc_next_c,
    output logic [XLEN-1:0] epc_next_c,
    output logic            misaligned_c
);

    logic target_bad;

    assign pc_plus_c = pc + XLEN'(INSTR_BYTES);

`ifdef PC_MISALIGN_TRAP_EN
    assign target_bad = (redirect_target % XLEN'(INSTR_BYTES)) != '0;
`else
    assign target_bad = 1'b0;
`endif

    // Trap entry beats everything; HALT only honours trap entry.
    always_comb begin
        pc_next_c    = pc;
        epc_next_c   = epc;
        misaligned_c = 1'b0;
        if (trap_req) begin
            pc_next_c  = TRAP_VECTOR;
            epc_next_c = pc;
        end else if (state == RUN) begin
            if (trap_ret) begin
                pc_next_c = epc;
            end else if (redirect_valid && enable) begin
                if (target_bad) begin
                    pc_next_c    = TRAP_VECTOR;
                    epc_next_c   = redirect_target;
                    misaligned_c = 1'b1;
                end else begin
                    pc_next_c = redirect_target;
                end
            end else if (enable) begin
                pc_next_c = pc_plus_c;
            end
        end
    end

endmodule : pc_next_sel

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: architectural PC/EPC registers and RUN/HALT control.
// Feature macro: PC_MISALIGN_TRAP_EN (handled in pc_next_sel).
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int unsigned     INSTR_BYTES  = INSTR_BYTES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    pc_sequencer_if.slave   bus
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            halted_q, halted_d;
    logic            misaligned_q, misaligned_d;

    logic [XLEN-1:0] pc_plus_c;
    logic [XLEN-1:0] pc_next_c;
    logic [XLEN-1:0] epc_next_c;
    logic            misaligned_c;

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_sel (
        .state           (state_q),
        .enable          (bus.enable),
        .redirect_valid  (bus.redirect_valid),
        .redirect_target (bus.redirect_target),
        .trap_req        (bus.trap_req),
        .trap_ret        (bus.trap_ret),
        .pc              (pc_q),
        .epc             (epc_q),
        .pc_plus_c       (pc_plus_c),
        .pc_next_c       (pc_next_c),
        .epc_next_c      (epc_next_c),
        .misaligned_c    (misaligned_c)
    );

    // Next state: halt after the current update; resume or trap entry leaves HALT.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_next_c;
        epc_d        = epc_next_c;
        misaligned_d = misaligned_c;
        unique case (state_q)
            RUN:  if (bus.halt_req) state_d = HALT;
            HALT: if (bus.trap_req || bus.resume) state_d = RUN;
            default: state_d = RUN;
        endcase
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            halted_q     <= halted_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus    = pc_plus_c;
    assign bus.epc        = epc_q;
    assign bus.halted     = halted_q;
    assign bus.misaligned = misaligned_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_VECTOR = 0x1000).
module tb_pc_sequencer;

    localparam int unsigned XLEN = 64;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    pc_sequencer_if #(.XLEN(XLEN)) bus ();

    pc_sequencer #(
        .XLEN         (XLEN),
        .RESET_VECTOR (64'h1000),
        .TRAP_VECTOR  (64'h100),
        .INSTR_BYTES  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle before inputs change or outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic rv, input logic [63:0] tgt,
                         input logic tq, input logic tr, input logic hq, input logic rs);
        bus.enable          = en;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.trap_req        = tq;
        bus.trap_ret        = tr;
        bus.halt_req        = hq;
        bus.resume          = rs;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        drive(0, 0, 64'h0, 0, 0, 0, 0);
        step();
        check_eq("rst_pc", bus.pc, 64'h1000);
        check_eq("rst_epc", bus.epc, 64'h0);
        check_eq("rst_halted", 64'(bus.halted), 64'h0);
        check_eq("rst_mis", 64'(bus.misaligned), 64'h0);
        check_eq("rst_pc_plus", bus.pc_plus, 64'h1004);
        reset = 1'b0;

        drive(1, 0, 64'h0, 0, 0, 0, 0);
        step(); check_eq("seq1", bus.pc, 64'h1004);
        step(); check_eq("seq2", bus.pc, 64'h1008);

        // Redirect while stalled is dropped.
        drive(0, 1, 64'h2000, 0, 0, 0, 0);
        step(); check_eq("stall1", bus.pc, 64'h1008);
        step(); check_eq("stall2", bus.pc, 64'h1008);
        drive(1, 1, 64'h2000, 0, 0, 0, 0);
        step(); check_eq("redir", bus.pc, 64'h2000);

        drive(0, 0, 64'h0, 1, 1, 0, 0);
        step();
        check_eq("trap_pc", bus.pc, 64'h100);
        check_eq("trap_epc", bus.epc, 64'h2000);
        drive(0, 0, 64'h0, 0, 1, 0, 0);
        step(); check_eq("mret_pc", bus.pc, 64'h2000);

        drive(1, 1, 64'h40, 0, 0, 0, 0);
        step(); check_eq("to_40", bus.pc, 64'h40);
        drive(1, 0, 64'h0, 0, 0, 1, 0);
        step();
        check_eq("halt_pc", bus.pc, 64'h44);
        check_eq("halt_flag", 64'(bus.halted), 64'h1);
        drive(1, 1, 64'h3000, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("halt_hold_pc", bus.pc, 64'h44);
            check_eq("halt_hold_flag", 64'(bus.halted), 64'h1);
        end
        drive(0, 0, 64'h0, 0, 0, 1, 1);
        step();
        check_eq("resume_flag", 64'(bus.halted), 64'h0);
        check_eq("resume_pc", bus.pc, 64'h44);
        drive(1, 0, 64'h0, 0, 0, 0, 0);
        step(); check_eq("post_resume", bus.pc, 64'h48);

        // Address wrap at the top of the space.
        drive(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
        step();
        check_eq("top_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("top_pc_plus", bus.pc_plus, 64'h0);
        drive(1, 0, 64'h0, 0, 0, 0, 0);
        step();
        check_eq("wrap_pc", bus.pc, 64'h0);
        check_eq("wrap_mis", 64'(bus.misaligned), 64'h0);
        step(); check_eq("after_wrap", bus.pc, 64'h4);

        // Trap entry from HALT.
        drive(0, 0, 64'h0, 0, 0, 1, 0);
        step(); check_eq("halt2_flag", 64'(bus.halted), 64'h1);
        drive(0, 0, 64'h0, 1, 0, 0, 0);
        step();
        check_eq("htrap_pc", bus.pc, 64'h100);
        check_eq("htrap_epc", bus.epc, 64'h4);
        check_eq("htrap_flag", 64'(bus.halted), 64'h0);

        // Reset while halted overrides pending trap.
        drive(0, 0, 64'h0, 0, 0, 1, 0);
        step(); check_eq("halt3_flag", 64'(bus.halted), 64'h1);
        drive(0, 0, 64'h0, 1, 0, 0, 0);
        reset = 1'b1;
        step();
        check_eq("hrst_pc", bus.pc, 64'h1000);
        check_eq("hrst_epc", bus.epc, 64'h0);
        check_eq("hrst_flag", 64'(bus.halted), 64'h0);
        reset = 1'b0;

        drive(1, 1, 64'h2002, 0, 0, 0, 0);
        step();
`ifdef PC_MISALIGN_TRAP_EN
        check_eq("mis_pc", bus.pc, 64'h100);
        check_eq("mis_epc", bus.epc, 64'h2002);
        check_eq("mis_flag", 64'(bus.misaligned), 64'h1);
`else
        check_eq("mis_pc", bus.pc, 64'h2002);
        check_eq("mis_epc", bus.epc, 64'h0);
        check_eq("mis_flag", 64'(bus.misaligned), 64'h0);
`endif
        drive(0, 0, 64'h0, 0, 0, 0, 0);
        step();
        check_eq("mis_pulse_end", 64'(bus.misaligned), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_sequencer
